// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending credit path.
package vend_pkg;

    localparam int CREDIT_W = 5;
    localparam int SUM_W    = CREDIT_W + 1;

    localparam int MAX_CREDIT_DEF = 31;
    localparam int COIN_A_DEF     = 1;
    localparam int COIN_B_DEF     = 5;
    localparam int COIN_C_DEF     = 10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HOLD       = 2'd1,
        VEND_OUT   = 2'd2,
        REFUND_OUT = 2'd3
    } vend_state_t;

    // One bit wider than the credit so an overflowing coin is seen, not wrapped.
    function automatic logic [SUM_W-1:0] add_coin(input logic [CREDIT_W-1:0] credit,
                                                  input logic [CREDIT_W-1:0] value);
        return {1'b0, credit} + {1'b0, value};
    endfunction

endpackage

// File: rtl/vend_input_sync.sv
// Two-flop synchroniser for one raw button level, followed by a registered
// rising-edge detector producing a single-cycle event pulse.
module vend_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= level;
            sync  <= meta;
            prev  <= sync;
            pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/vend_credit_accumulator.sv
// Coin/vend/refund front end: accumulates a 5-bit credit fed to the BCD
// converter and issues dispense, change, reject and insufficient-credit pulses.
//
// state      | meaning
// IDLE       | no credit held
// HOLD       | credit > 0, accepting coins / vend / refund
// VEND_OUT   | one-cycle: item dispensed, change paid, credit cleared
// REFUND_OUT | one-cycle: credit paid back as change, credit cleared
module vend_credit_accumulator
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = MAX_CREDIT_DEF,
    parameter int COIN_A_VAL = COIN_A_DEF,
    parameter int COIN_B_VAL = COIN_B_DEF,
    parameter int COIN_C_VAL = COIN_C_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                COIN_A,
    input  logic                COIN_B,
    input  logic                COIN_C,
    input  logic                VEND,
    input  logic                REFUND,
    input  logic [CREDIT_W-1:0] PRICE,
    output logic                C0,
    output logic                S3,
    output logic                S2,
    output logic                S1,
    output logic                S0,
    output logic                DISPENSE,
    output logic [CREDIT_W-1:0] CHANGE,
    output logic                CHANGE_VALID,
    output logic                REJECT,
    output logic                INSUFF
);

    localparam logic [CREDIT_W-1:0] VAL_A = CREDIT_W'(COIN_A_VAL);
    localparam logic [CREDIT_W-1:0] VAL_B = CREDIT_W'(COIN_B_VAL);
    localparam logic [CREDIT_W-1:0] VAL_C = CREDIT_W'(COIN_C_VAL);
    localparam logic [SUM_W-1:0]    LIMIT = SUM_W'(MAX_CREDIT);

    logic ev_a;
    logic ev_b;
    logic ev_c;
    logic ev_vend;
    logic ev_refund;

    vend_input_sync u_sync_a      (.clk(CLK), .rst_n(RST_N), .level(COIN_A), .pulse(ev_a));
    vend_input_sync u_sync_b      (.clk(CLK), .rst_n(RST_N), .level(COIN_B), .pulse(ev_b));
    vend_input_sync u_sync_c      (.clk(CLK), .rst_n(RST_N), .level(COIN_C), .pulse(ev_c));
    vend_input_sync u_sync_vend   (.clk(CLK), .rst_n(RST_N), .level(VEND),   .pulse(ev_vend));
    vend_input_sync u_sync_refund (.clk(CLK), .rst_n(RST_N), .level(REFUND), .pulse(ev_refund));

    vend_state_t         state;
    vend_state_t         state_next;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_next;

    logic                dispense_next;
    logic [CREDIT_W-1:0] change_next;
    logic                change_valid_next;
    logic                reject_next;
    logic                insuff_next;

    logic [CREDIT_W-1:0] coin_val;
    logic                coin_any;
    logic                coin_drop;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_fits;
    logic                refund_go;
    logic                vend_ok;

    // Decision terms shared by the next-state and output logic.
    always_comb begin
        coin_val = '0;
        if (ev_c) begin
            coin_val = VAL_C;
        end else if (ev_b) begin
            coin_val = VAL_B;
        end else if (ev_a) begin
            coin_val = VAL_A;
        end
        coin_any  = ev_a | ev_b | ev_c;
        coin_drop = (ev_a & ev_b) | (ev_a & ev_c) | (ev_b & ev_c);
        coin_sum  = add_coin(credit, coin_val);
        coin_fits = (coin_sum <= LIMIT);
        // A refund with nothing to pay back is a no-op and does not
        // pre-empt a vend or coin arriving in the same cycle.
        refund_go = ev_refund && (credit != '0);
        vend_ok   = (PRICE != '0) && (credit >= PRICE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            credit       <= '0;
            DISPENSE     <= 1'b0;
            CHANGE       <= '0;
            CHANGE_VALID <= 1'b0;
            REJECT       <= 1'b0;
            INSUFF       <= 1'b0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            DISPENSE     <= dispense_next;
            CHANGE       <= change_next;
            CHANGE_VALID <= change_valid_next;
            REJECT       <= reject_next;
            INSUFF       <= insuff_next;
        end
    end

    always_comb begin
        state_next  = state;
        credit_next = credit;
        case (state)
            IDLE, HOLD: begin
                if (refund_go) begin
                    state_next  = REFUND_OUT;
                    credit_next = '0;
                end else if (ev_vend) begin
                    if (vend_ok) begin
                        state_next  = VEND_OUT;
                        credit_next = '0;
                    end
                end else begin
                    if (coin_any && coin_fits) begin
                        credit_next = coin_sum[CREDIT_W-1:0];
                    end
                    state_next = (credit_next == '0) ? IDLE : HOLD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        dispense_next     = 1'b0;
        change_next       = '0;
        change_valid_next = 1'b0;
        reject_next       = 1'b0;
        insuff_next       = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (refund_go) begin
                    change_valid_next = 1'b1;
                    change_next       = credit;
                    reject_next       = coin_any;
                end else if (ev_vend) begin
                    reject_next = coin_any;
                    if (vend_ok) begin
                        dispense_next     = 1'b1;
                        change_valid_next = 1'b1;
                        change_next       = credit - PRICE;
                    end else begin
                        insuff_next = 1'b1;
                    end
                end else if (coin_any) begin
                    reject_next = !coin_fits || coin_drop;
                end
            end
            default: begin
                reject_next = coin_any;
            end
        endcase
    end

    assign C0 = credit[4];
    assign S3 = credit[3];
    assign S2 = credit[2];
    assign S1 = credit[1];
    assign S0 = credit[0];

endmodule

// File: tb/tb_vend_credit_accumulator.sv
// Directed bench for vend_credit_accumulator: a vector table of button presses
// with hand-computed results, plus latency, busy-cycle and reset sequences.
module tb_vend_credit_accumulator;

    logic       CLK;
    logic       RST_N;
    logic       COIN_A, COIN_B, COIN_C, VEND, REFUND;
    logic [4:0] PRICE;
    logic       C0, S3, S2, S1, S0;
    logic       DISPENSE;
    logic [4:0] CHANGE;
    logic       CHANGE_VALID, REJECT, INSUFF;

    int n_cmp = 0;
    int n_err = 0;

    vend_credit_accumulator dut (
        .CLK(CLK), .RST_N(RST_N),
        .COIN_A(COIN_A), .COIN_B(COIN_B), .COIN_C(COIN_C),
        .VEND(VEND), .REFUND(REFUND), .PRICE(PRICE),
        .C0(C0), .S3(S3), .S2(S2), .S1(S1), .S0(S0),
        .DISPENSE(DISPENSE), .CHANGE(CHANGE), .CHANGE_VALID(CHANGE_VALID),
        .REJECT(REJECT), .INSUFF(INSUFF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int a, b, c, vend, refund, price;
        int credit, disp, cv, change, rej, ins;
    } vec_t;

    vec_t vecs[28];

    function automatic int credit_now();
        return int'({C0, S3, S2, S1, S0});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic release_inputs();
        COIN_A = 0; COIN_B = 0; COIN_C = 0; VEND = 0; REFUND = 0;
    endtask

    // Press the requested buttons for 5 cycles, then watch 7 more cycles,
    // counting every pulse so both missing and stretched pulses show up.
    task automatic run_vec(input vec_t v, input string name);
        int nd, ncv, nrej, nins, chg, badchg;
        nd = 0; ncv = 0; nrej = 0; nins = 0; chg = 0; badchg = 0;
        @(negedge CLK);
        COIN_A = v.a[0]; COIN_B = v.b[0]; COIN_C = v.c[0];
        VEND = v.vend[0]; REFUND = v.refund[0]; PRICE = v.price[4:0];
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            nd   += int'(DISPENSE);
            nrej += int'(REJECT);
            nins += int'(INSUFF);
            if (CHANGE_VALID) begin
                ncv++;
                chg = int'(CHANGE);
            end else if (CHANGE != 5'd0) begin
                badchg++;
            end
            if (i == 4) release_inputs();
        end
        check({name, " credit"},    credit_now(), v.credit);
        check({name, " dispense"},  nd,   v.disp);
        check({name, " chg_valid"}, ncv,  v.cv);
        check({name, " change"},    chg,  v.change);
        check({name, " reject"},    nrej, v.rej);
        check({name, " insuff"},    nins, v.ins);
        check({name, " chg_idle0"}, badchg, 0);
    endtask

    initial begin
        int old_credit, cv_at, rej_at;
        //          a  b  c  v  r  pr  cred d cv chg rej ins
        vecs[0]  = '{0, 0, 1, 0, 0, 0,  10, 0, 0, 0,  0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0,  15, 0, 0, 0,  0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 0,  16, 0, 0, 0,  0, 0};
        vecs[3]  = '{0, 0, 0, 1, 0, 12, 0,  1, 1, 4,  0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 12, 5,  0, 0, 0,  0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0, 12, 6,  0, 0, 0,  0, 0};
        vecs[6]  = '{1, 0, 0, 0, 0, 12, 7,  0, 0, 0,  0, 0};
        vecs[7]  = '{0, 0, 0, 1, 0, 12, 7,  0, 0, 0,  0, 1};
        vecs[8]  = '{0, 0, 0, 1, 0, 0,  7,  0, 0, 0,  0, 1};
        vecs[9]  = '{0, 0, 0, 0, 1, 0,  0,  0, 1, 7,  0, 0};
        vecs[10] = '{0, 0, 1, 0, 0, 0,  10, 0, 0, 0,  0, 0};
        vecs[11] = '{0, 0, 1, 0, 0, 0,  20, 0, 0, 0,  0, 0};
        vecs[12] = '{0, 1, 0, 0, 0, 0,  25, 0, 0, 0,  0, 0};
        vecs[13] = '{0, 0, 1, 0, 0, 0,  25, 0, 0, 0,  1, 0};
        vecs[14] = '{0, 1, 0, 0, 0, 0,  30, 0, 0, 0,  0, 0};
        vecs[15] = '{1, 0, 0, 0, 0, 0,  31, 0, 0, 0,  0, 0};
        vecs[16] = '{1, 0, 0, 0, 0, 0,  31, 0, 0, 0,  1, 0};
        vecs[17] = '{0, 0, 0, 1, 0, 31, 0,  1, 1, 0,  0, 0};
        vecs[18] = '{1, 0, 1, 0, 0, 31, 10, 0, 0, 0,  1, 0};
        vecs[19] = '{0, 0, 0, 0, 1, 31, 0,  0, 1, 10, 0, 0};
        vecs[20] = '{0, 1, 0, 0, 0, 31, 5,  0, 0, 0,  0, 0};
        vecs[21] = '{1, 0, 0, 0, 0, 31, 6,  0, 0, 0,  0, 0};
        vecs[22] = '{0, 1, 0, 0, 1, 31, 0,  0, 1, 6,  1, 0};
        vecs[23] = '{0, 0, 0, 0, 1, 31, 0,  0, 0, 0,  0, 0};
        vecs[24] = '{1, 0, 0, 1, 0, 5,  0,  0, 0, 0,  1, 1};
        vecs[25] = '{1, 1, 1, 0, 0, 5,  10, 0, 0, 0,  1, 0};
        vecs[26] = '{0, 0, 0, 1, 0, 10, 0,  1, 1, 0,  0, 0};
        vecs[27] = '{0, 1, 0, 0, 0, 10, 5,  0, 0, 0,  0, 0};

        release_inputs();
        PRICE = 5'd0;
        RST_N = 1'b0;
        #2;
        check("reset credit",   credit_now(), 0);
        check("reset dispense", int'(DISPENSE), 0);
        check("reset chg_valid", int'(CHANGE_VALID), 0);
        check("reset reject",   int'(REJECT), 0);
        check("reset insuff",   int'(INSUFF), 0);
        check("reset change",   int'(CHANGE), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 28; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Latency: first sampled at edge k, credit changes only at edge k+3.
        old_credit = credit_now();
        @(negedge CLK);
        COIN_A = 1'b1;
        repeat (3) @(posedge CLK);
        #1 check("lat k+2 credit", credit_now(), old_credit);
        @(posedge CLK);
        #1 check("lat k+3 credit", credit_now(), old_credit + 1);
        repeat (6) @(negedge CLK);
        release_inputs();
        repeat (6) @(negedge CLK);
        check("lat one per press", credit_now(), old_credit + 1);

        // Coin event landing in the REFUND_OUT cycle is rejected, one cycle later.
        cv_at = -1; rej_at = -1;
        @(negedge CLK);
        REFUND = 1'b1;
        @(negedge CLK);
        COIN_A = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (CHANGE_VALID && cv_at < 0) begin
                cv_at = i;
                check("busy change", int'(CHANGE), old_credit + 1);
            end
            if (REJECT && rej_at < 0) rej_at = i;
            if (i == 4) release_inputs();
        end
        check("busy cv seen", int'(cv_at >= 0), 1);
        check("busy reject delay", rej_at - cv_at, 1);
        check("busy credit", credit_now(), 0);
        run_vec('{1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0}, "post_busy");

        // Build credit 15, then assert reset between edges while INSUFF is high.
        run_vec('{0, 0, 0, 0, 1, 10, 0,  0, 1, 1, 0, 0}, "pre_rst_refund");
        run_vec('{0, 0, 1, 0, 0, 20, 10, 0, 0, 0, 0, 0}, "pre_rst_c");
        run_vec('{0, 1, 0, 0, 0, 20, 15, 0, 0, 0, 0, 0}, "pre_rst_b");
        @(negedge CLK);
        VEND = 1'b1;
        repeat (4) @(posedge CLK);
        #2 check("pre_rst insuff", int'(INSUFF), 1);
        RST_N = 1'b0;
        #1;
        check("mid_rst credit", credit_now(), 0);
        check("mid_rst insuff", int'(INSUFF), 0);
        check("mid_rst reject", int'(REJECT), 0);
        check("mid_rst chg_valid", int'(CHANGE_VALID), 0);
        repeat (2) @(negedge CLK);
        release_inputs();
        RST_N = 1'b1;
        run_vec('{1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 0}, "post_rst_a");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vend_credit_accumulator.md
Name: vend_credit_accumulator

Overview:
Upstream stage of the vending-machine display path. Synchronises and edge-detects the coin, vend and refund buttons, and maintains a registered 5-bit credit (0..31). It drives that credit as C0,S3..S0 straight into the binary-to-BCD converter. It also handles vend (credit minus price, change out) and refund, using a small FSM.

Parameters:
MAX_CREDIT, 31, highest credit held; must be ≤31.
COIN_A_VAL, 1, value added by COIN_A.
COIN_B_VAL, 5, value added by COIN_B.
COIN_C_VAL, 10, value added by COIN_C.

Ports:
CLK  in  1  system clock; all state on rising edge.
RST_N  in  1  asynchronous active-low reset.
COIN_A  in  1  raw coin button/sensor level, asynchronous.
COIN_B  in  1  raw coin level, asynchronous.
COIN_C  in  1  raw coin level, asynchronous.
VEND  in  1  raw vend request level, asynchronous.
REFUND  in  1  raw refund request level, asynchronous.
PRICE  in  5  item price, quasi-static; sampled on the vend event cycle.
C0  out  1  credit bit 4 (MSB), to converter.
S3,S2,S1,S0  out  1 each  credit bits 3..0, to converter.
DISPENSE  out  1  one-cycle pulse: item released.
CHANGE  out  5  change amount; valid while CHANGE_VALID=1, otherwise 0.
CHANGE_VALID  out  1  one-cycle pulse.
REJECT  out  1  one-cycle pulse: coin not accepted.
INSUFF  out  1  one-cycle pulse: vend refused.

Behaviour:
- Reset (RST_N=0, asynchronous): credit=0, FSM=IDLE, all sync/edge flops=0, all outputs 0. Release is synchronous to CLK (no partial state).
- Each raw input: 2-flop synchroniser, then a third flop for rising-edge detect. An event is a single-cycle pulse; levels held high produce one event only.
- Latency: the input is first sampled high at edge k. The event is active in cycle k+2→k+3. Credit/pulse outputs update at edge k+3.
- FSM states:
  - IDLE (credit=0)
  - HOLD (credit>0)
  - VEND_OUT
  - REFUND_OUT
  - VEND_OUT and REFUND_OUT each last exactly one cycle, then go to IDLE.
- Event priority in the same cycle: REFUND > VEND > coins.
  - A coin event that loses to REFUND/VEND → REJECT pulse, credit unaffected by it.
- Multiple coin events in the same cycle: accept only the highest (C > B > A); REJECT pulses once for the dropped ones.
- Coin accept: if credit+value ≤ MAX_CREDIT, credit += value (6-bit internal sum, no wrap). Else credit unchanged, REJECT=1.
- VEND event, in IDLE or HOLD:
  - PRICE≠0 and credit ≥ PRICE → enter VEND_OUT. In that cycle: DISPENSE=1, CHANGE=credit−PRICE, CHANGE_VALID=1 (even if change is 0), credit=0.
  - Otherwise INSUFF=1, state and credit unchanged.
- REFUND event:
  - credit>0 → REFUND_OUT: CHANGE=credit, CHANGE_VALID=1, credit=0.
  - credit=0 → no action, no pulses.
- Events arriving while in VEND_OUT/REFUND_OUT: coins → REJECT, credit not changed; VEND/REFUND are dropped silently.
- C0,S3..S0 are always the registered credit; they never show intermediate sums.
- Pulse outputs are registered and never high for more than 1 cycle per event.

Decomposition:
- Shared package vend_pkg: FSM state encoding (IDLE=2'd0, HOLD=2'd1, VEND_OUT=2'd2, REFUND_OUT=2'd3), CREDIT_W=5, default coin values.
- One sub-module: vend_input_sync (2-flop sync + edge detect, one instance per raw input, five instances).

Test Plan:
1. Reset mid-operation:
   - Stimulus: credit=15, assert RST_N=0 asynchronously between edges.
   - Required: C0..S0=0 and all pulses 0 immediately; after release, COIN_A → credit 1.
2. Coin accumulation and latency:
   - Stimulus: COIN_C, COIN_B, COIN_A held high 5 cycles each.
   - Required: credit 10 → 15 → 16. Each update lands at the 3rd edge after the rise; one increment per press.
3. Saturation:
   - Stimulus: credit=25, COIN_C.
   - Required: REJECT pulse, credit stays 25. Then COIN_B → 30, COIN_A → 31, COIN_A → REJECT, credit 31.
4. Vend:
   - PRICE=12, credit=16, VEND → DISPENSE=1, CHANGE=4, CHANGE_VALID=1 for one cycle; credit=0.
   - PRICE=12, credit=7, VEND → INSUFF=1, credit stays 7.
   - PRICE=0 → INSUFF.
5. Simultaneous events:
   - Stimulus: credit=6; REFUND and COIN_B edges in the same cycle.
   - Required: CHANGE=6, CHANGE_VALID=1, REJECT=1, credit=0.
   - Stimulus: COIN_A and COIN_C together.
   - Required: credit +10, REJECT=1.
6. Refund at zero:
   - Stimulus: REFUND with credit=0.
   - Required: no pulses, state IDLE.
   - Stimulus: coin during the REFUND_OUT cycle.
   - Required: REJECT=1, credit 0.
